// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute control unit for the phase-2 CPU.
// The state register walks RST -> T0..T6 -> T0 or HALT. Every strobe is a Moore
// decode of the state plus the opcode in IR[31:27].
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [31:0]    IR,
  input  logic           Stop,
  output logic           PCout,
  output logic           Zhighout,
  output logic           Zlowout,
  output logic           MDRout,
  output logic           MARin,
  output logic           Zin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           HIin,
  output logic           LOin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] alu_op,
  output logic           Run
);

  typedef enum logic [3:0] {
    RST  = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    HALT = 4'd8
  } state_t;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  state_t           state_reg;
  state_t           state_next;
  state_t           fetch_next;
  logic [OPW-1:0]   opcode;
  logic             is_alu;
  logic             is_muldiv;
  logic             is_halt;

  // Register-field bits are consumed by the datapath's select logic, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[31-OPW:0];

  assign opcode    = IR[31 -: OPW];
  assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_halt   = (opcode == OP_HALT);

  // Stop only takes effect on a transition that would otherwise begin a new fetch.
  assign fetch_next = Stop ? HALT : T0;

  // State register; Reset forces RST from any state, including HALT.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= RST;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and Moore strobe decode; every output defaults to 0.
  always_comb begin
    state_next = state_reg;
    PCout      = 1'b0;
    Zhighout   = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    alu_op     = '0;
    Run        = 1'b0;
    unique case (state_reg)
      RST: begin
        state_next = fetch_next;
      end
      T0: begin
        Run        = 1'b1;
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin        = 1'b1;
        state_next = T1;
      end
      T1: begin
        Run        = 1'b1;
        Zlowout    = 1'b1;
        PCin       = 1'b1;
        Read       = 1'b1;
        MDRin      = 1'b1;
        state_next = T2;
      end
      T2: begin
        Run        = 1'b1;
        MDRout     = 1'b1;
        IRin       = 1'b1;
        state_next = T3;
      end
      T3: begin
        Run  = 1'b1;
        Grb  = 1'b1;
        Rout = 1'b1;
        Yin  = 1'b1;
        if (is_halt) begin
          state_next = HALT;
        end else if (is_alu || is_muldiv) begin
          state_next = T4;
        end else begin
          state_next = fetch_next;
        end
      end
      T4: begin
        Run        = 1'b1;
        Grc        = 1'b1;
        Rout       = 1'b1;
        Zin        = 1'b1;
        alu_op     = opcode;
        state_next = T5;
      end
      T5: begin
        Run = 1'b1;
        if (is_muldiv) begin
          Zlowout    = 1'b1;
          LOin       = 1'b1;
          state_next = T6;
        end else if (is_alu) begin
          Zlowout    = 1'b1;
          Gra        = 1'b1;
          Rin        = 1'b1;
          state_next = fetch_next;
        end else begin
          state_next = fetch_next;
        end
      end
      T6: begin
        Run        = 1'b1;
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        state_next = fetch_next;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = RST;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed-step bench for control_sequencer. Each step
// clocks once and compares the full strobe/alu_op/Run word against a
// hand-built constant, plus the single-bus-driver rule.
module tb_control_sequencer;

  logic        Clock;
  logic        Reset;
  logic [31:0] IR;
  logic        Stop;
  logic PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
  logic HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run;
  logic [4:0]  alu_op;

  int compared   = 0;
  int mismatched = 0;

  // Strobe bit positions in the packed observation word.
  localparam int B_PCOUT = 18, B_ZHI = 17, B_ZLO = 16, B_MDROUT = 15, B_MARIN = 14;
  localparam int B_ZIN = 13, B_PCIN = 12, B_MDRIN = 11, B_IRIN = 10, B_YIN = 9;
  localparam int B_HIIN = 8, B_LOIN = 7, B_INCPC = 6, B_READ = 5, B_GRA = 4;
  localparam int B_GRB = 3, B_GRC = 2, B_RIN = 1, B_ROUT = 0;

  localparam logic [18:0] ONE  = 19'd1;
  localparam logic [18:0] E_0  = 19'd0;
  localparam logic [18:0] E_T0 = (ONE << B_PCOUT) | (ONE << B_MARIN) | (ONE << B_INCPC) | (ONE << B_ZIN);
  localparam logic [18:0] E_T1 = (ONE << B_ZLO) | (ONE << B_PCIN) | (ONE << B_READ) | (ONE << B_MDRIN);
  localparam logic [18:0] E_T2 = (ONE << B_MDROUT) | (ONE << B_IRIN);
  localparam logic [18:0] E_T3 = (ONE << B_GRB) | (ONE << B_ROUT) | (ONE << B_YIN);
  localparam logic [18:0] E_T4 = (ONE << B_GRC) | (ONE << B_ROUT) | (ONE << B_ZIN);
  localparam logic [18:0] E_T5A = (ONE << B_ZLO) | (ONE << B_GRA) | (ONE << B_RIN);
  localparam logic [18:0] E_T5M = (ONE << B_ZLO) | (ONE << B_LOIN);
  localparam logic [18:0] E_T6 = (ONE << B_ZHI) | (ONE << B_HIIN);

  control_sequencer #(.OPW(5)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .Run(Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one clock, then compare outputs 1 time unit after the edge.
  task automatic step(input string tag, input logic [18:0] exp_strobes,
                      input logic exp_run, input logic [4:0] exp_alu);
    logic [24:0] observed;
    logic [24:0] expected;
    int          drivers;
    @(posedge Clock);
    #1;
    observed = {PCout, Zhighout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                Yin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run, alu_op};
    expected = {exp_strobes, exp_run, exp_alu};
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
    drivers = int'(PCout) + int'(Zhighout) + int'(Zlowout) + int'(MDRout) + int'(Rout);
    compared++;
    assert (drivers <= 1) else begin
      mismatched++;
      $display("FAIL %s_bus: observed %0d drivers expected <=1", tag, drivers);
    end
    $display("step %-10s strobes=%05h run=%b alu_op=%05b", tag, observed[24:6], Run, alu_op);
  endtask

  initial begin
    Reset = 1'b1;
    Stop  = 1'b0;
    IR    = 32'h1A92_0000;   // add R5,R2,R4

    // Reset held three cycles: everything quiet.
    step("rst0", E_0, 1'b0, 5'd0);
    step("rst1", E_0, 1'b0, 5'd0);
    step("rst2", E_0, 1'b0, 5'd0);

    // add: T0..T5 then back to T0 (6 cycles).
    Reset = 1'b0;
    step("add_t0", E_T0, 1'b1, 5'd0);
    step("add_t1", E_T1, 1'b1, 5'd0);
    step("add_t2", E_T2, 1'b1, 5'd0);
    step("add_t3", E_T3, 1'b1, 5'd0);
    step("add_t4", E_T4, 1'b1, 5'b00011);
    step("add_t5", E_T5A, 1'b1, 5'd0);
    step("add_nt0", E_T0, 1'b1, 5'd0);

    // div: T5 low half, T6 high half, then T0 (7 cycles).
    IR = 32'h8292_0000;
    step("div_t1", E_T1, 1'b1, 5'd0);
    step("div_t2", E_T2, 1'b1, 5'd0);
    step("div_t3", E_T3, 1'b1, 5'd0);
    step("div_t4", E_T4, 1'b1, 5'b10000);
    step("div_t5", E_T5M, 1'b1, 5'd0);
    step("div_t6", E_T6, 1'b1, 5'd0);
    step("div_nt0", E_T0, 1'b1, 5'd0);

    // sub: same shape as add, different alu_op.
    IR = 32'h2292_0000;
    step("sub_t1", E_T1, 1'b1, 5'd0);
    step("sub_t2", E_T2, 1'b1, 5'd0);
    step("sub_t3", E_T3, 1'b1, 5'd0);
    step("sub_t4", E_T4, 1'b1, 5'b00100);
    step("sub_t5", E_T5A, 1'b1, 5'd0);
    step("sub_nt0", E_T0, 1'b1, 5'd0);

    // halt: T3 then HALT for 20 cycles.
    IR = 32'hD800_0000;
    step("hlt_t1", E_T1, 1'b1, 5'd0);
    step("hlt_t2", E_T2, 1'b1, 5'd0);
    step("hlt_t3", E_T3, 1'b1, 5'd0);
    for (int i = 0; i < 20; i++) begin
      step("hlt_idle", E_0, 1'b0, 5'd0);
    end

    // Reset pulse leaves HALT and restarts at T0.
    Reset = 1'b1;
    step("hlt_rst", E_0, 1'b0, 5'd0);
    Reset = 1'b0;
    step("rst_t0", E_T0, 1'b1, 5'd0);

    // mul with Stop raised in T4: T5 and T6 still run, then HALT, no T0.
    IR = 32'h7A92_0000;
    step("mul_t1", E_T1, 1'b1, 5'd0);
    step("mul_t2", E_T2, 1'b1, 5'd0);
    step("mul_t3", E_T3, 1'b1, 5'd0);
    step("mul_t4", E_T4, 1'b1, 5'b01111);
    Stop = 1'b1;
    step("mul_t5", E_T5M, 1'b1, 5'd0);
    step("mul_t6", E_T6, 1'b1, 5'd0);
    step("stp_hlt0", E_0, 1'b0, 5'd0);
    step("stp_hlt1", E_0, 1'b0, 5'd0);
    Stop = 1'b0;
    step("stp_hlt2", E_0, 1'b0, 5'd0);

    // Reset in T4 of an add aborts it before any Rin.
    Reset = 1'b1;
    IR    = 32'h1A92_0000;
    step("ab_rst", E_0, 1'b0, 5'd0);
    Reset = 1'b0;
    step("ab_t0", E_T0, 1'b1, 5'd0);
    step("ab_t1", E_T1, 1'b1, 5'd0);
    step("ab_t2", E_T2, 1'b1, 5'd0);
    step("ab_t3", E_T3, 1'b1, 5'd0);
    step("ab_t4", E_T4, 1'b1, 5'b00011);
    Reset = 1'b1;
    step("ab_rst2", E_0, 1'b0, 5'd0);
    Reset = 1'b0;
    step("ab_nt0", E_T0, 1'b1, 5'd0);

    // Undecoded opcode: T3 goes straight back to T0 (4 cycles).
    IR = 32'hF800_0000;
    step("und_t1", E_T1, 1'b1, 5'd0);
    step("und_t2", E_T2, 1'b1, 5'd0);
    step("und_t3", E_T3, 1'b1, 5'd0);
    step("und_nt0", E_T0, 1'b1, 5'd0);

    // nop behaves the same way.
    IR = 32'hD000_0000;
    step("nop_t1", E_T1, 1'b1, 5'd0);
    step("nop_t2", E_T2, 1'b1, 5'd0);
    step("nop_t3", E_T3, 1'b1, 5'd0);
    step("nop_nt0", E_T0, 1'b1, 5'd0);

    // Stop seen on the T3 -> T0 edge of a nop goes to HALT instead.
    step("nps_t1", E_T1, 1'b1, 5'd0);
    step("nps_t2", E_T2, 1'b1, 5'd0);
    step("nps_t3", E_T3, 1'b1, 5'd0);
    Stop = 1'b1;
    step("nps_hlt", E_0, 1'b0, 5'd0);
    Stop = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
